multi_cycle_cpu: RTL

- Parametrised multi-cycle MIPS-subset core; successor to the single-cycle CPU.
- Executes each instruction over 3–5+ states through a single shared datapath, and talks to one unified instruction/data memory over a ready/valid handshake that tolerates wait states.
- Adds address-width and reset-vector parameters, `bne`/`j`/`lw`/`sw`, a halt state, a retire strobe and a debug register read port.
- Top-level CPU instance in the lab test harness; memory sits outside the block.

---
 rtl/multi_cycle_cpu.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-subset core sharing one datapath and one ready/valid memory port
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   mem_req_o/we_o/addr_o/wdata_o registered memory request, held until mem_req_o & mem_ready_i
//   mem_rdata_i, mem_ready_i     memory response
//   pc_o, retire_o, halted_o     current PC, one-cycle retire pulse, HALT indicator
//   dbg_addr_i, dbg_data_o       combinational register file read port
module multi_cycle_cpu #(
   parameter int          ADDR_W       = 32,
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter bit          TRAP_ILLEGAL = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              retire_o,
   output logic              halted_o,
   input  logic [4:0]        dbg_addr_i,
   output logic [31:0]       dbg_data_o
);
   localparam logic [ADDR_W-1:0] RPC = RESET_PC[ADDR_W-1:0];
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t state, state_n;
   logic [31:0] ir, a, b, alu_r, mdr, imm, alu_y, pc4_32, jt32, wb_data, wdata_n;
   logic [31:0] rf [32];
   logic [ADDR_W-1:0] pc, pc4, br_tgt, tgt, addr_n;
   logic [5:0] op, fn;
   logic [4:0] wdst;
   logic is_r, legal, halt_w, ldst, misal, taken;
   logic ret, ld_ir, ld_ab, ld_alu, ld_mdr, wr_reg, req_n, we_n;
   assign op = ir[31:26];
   assign fn = ir[5:0];
   assign imm = {{16{ir[15]}}, ir[15:0]};
   assign is_r = op == 6'h00;
   assign legal = is_r ? (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                       : (op inside {6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B});
   assign halt_w = &ir;
   assign ldst = op == 6'h23 || op == 6'h2B;
   assign alu_y = !is_r ? (op == 6'h0A ? {31'b0, $signed(a) < $signed(imm)} : a + imm)
                : fn == 6'h20 ? a + b
                : fn == 6'h22 ? a - b
                : fn == 6'h24 ? a & b
                : fn == 6'h25 ? a | b
                : {31'b0, $signed(a) < $signed(b)};
   assign misal = |alu_y[1:0];
   assign taken = (a == b) ^ (op == 6'h05);
   assign br_tgt = pc4 + {imm[ADDR_W-3:0], 2'b00};
   // jump target built at 32 bits so narrow ADDR_W simply truncates it
   assign pc4_32 = 32'(pc4);
   assign jt32 = {pc4_32[31:28], ir[25:0], 2'b00};
   assign wdst = is_r ? ir[15:11] : ir[20:16];
   assign wb_data = op == 6'h23 ? mdr : alu_r;
   assign pc_o = pc;
   assign halted_o = state == HALT;
   assign dbg_data_o = rf[dbg_addr_i];
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= FETCH;
      else state <= state_n;
   always_comb begin
      state_n = state;
      ret = 1'b0;
      tgt = pc4;
      ld_ir = 1'b0;
      ld_ab = 1'b0;
      ld_alu = 1'b0;
      ld_mdr = 1'b0;
      wr_reg = 1'b0;
      req_n = mem_req_o;
      we_n = mem_we_o;
      addr_n = mem_addr_o;
      wdata_n = mem_wdata_o;
      case (state)
         FETCH:
            if (!mem_req_o) begin
               req_n = 1'b1;
               addr_n = pc;
            end else if (mem_ready_i) begin
               req_n = 1'b0;
               ld_ir = 1'b1;
               state_n = DECODE;
            end
         DECODE: begin
            ld_ab = 1'b1;
            if (halt_w || (!legal && TRAP_ILLEGAL)) state_n = HALT;
            else if (!legal) ret = 1'b1;
            else state_n = EXEC;
         end
         EXEC:
            if (op == 6'h04 || op == 6'h05) begin
               ret = 1'b1;
               tgt = taken ? br_tgt : pc4;
            end else if (op == 6'h02) begin
               ret = 1'b1;
               tgt = jt32[ADDR_W-1:0];
            end else if (ldst) begin
               if (misal) state_n = HALT;
               else begin
                  req_n = 1'b1;
                  we_n = op == 6'h2B;
                  addr_n = alu_y[ADDR_W-1:0];
                  wdata_n = b;
                  state_n = MEM;
               end
            end else begin
               ld_alu = 1'b1;
               state_n = WB;
            end
         MEM:
            if (mem_ready_i) begin
               req_n = 1'b0;
               we_n = 1'b0;
               if (op == 6'h2B) ret = 1'b1;
               else begin
                  ld_mdr = 1'b1;
                  state_n = WB;
               end
            end
         WB: begin
            wr_reg = 1'b1;
            ret = 1'b1;
         end
         default: ;
      endcase
      // retiring always launches the next fetch in the same edge
      if (ret) begin
         state_n = FETCH;
         req_n = 1'b1;
         we_n = 1'b0;
         addr_n = tgt;
      end
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         mem_req_o <= 1'b0;
         mem_we_o <= 1'b0;
         mem_addr_o <= RPC;
         mem_wdata_o <= '0;
         retire_o <= 1'b0;
         pc <= RPC;
         pc4 <= RPC;
         ir <= '0;
         a <= '0;
         b <= '0;
         alu_r <= '0;
         mdr <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         mem_req_o <= req_n;
         mem_we_o <= we_n;
         mem_addr_o <= addr_n;
         mem_wdata_o <= wdata_n;
         retire_o <= ret;
         if (ret) pc <= tgt;
         if (ld_ir) begin
            ir <= mem_rdata_i;
            pc4 <= pc + ADDR_W'(4);
         end
         if (ld_ab) begin
            a <= rf[ir[25:21]];
            b <= rf[ir[20:16]];
         end
         if (ld_alu) alu_r <= alu_y;
         if (ld_mdr) mdr <= mem_rdata_i;
         if (wr_reg && wdst != 5'd0) rf[wdst] <= wb_data;
      end
endmodule
